// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: byte-level command responder between a UART byte
// interface and a single-cycle register bus.
//   'W' addr data -> register write, answers 'K'
//   'R' addr      -> register read, answers the read byte
//   anything else -> answers '?' and pulses frame_err
// Exactly one response byte per accepted command. Bytes that arrive while a
// command is being executed or answered are dropped and flagged.
// Optional build macro UART_BRIDGE_TIMEOUT_EN: abandons a partial command
// after TIMEOUT_CYCLES idle clocks between its bytes. Without the macro a
// partial command waits indefinitely.
module uart_reg_bridge #(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              frame_err
);

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h3F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_BUS_WR,
        S_BUS_RD,
        S_RD_CAP,
        S_TX_SEND,
        S_TX_WAIT
    } state_t;

    state_t              r_state;
    logic                r_cmd_rd;
    logic [7:0]          r_tx_data;
    logic                r_tx_start;
    logic [ADDR_W-1:0]   r_reg_addr;
    logic [7:0]          r_reg_wdata;
    logic                r_reg_we;
    logic                r_reg_re;
    logic                r_frame_err;

    state_t              w_state_nxt;
    logic                w_cmd_rd_nxt;
    logic [7:0]          w_tx_data_nxt;
    logic                w_tx_start_nxt;
    logic [ADDR_W-1:0]   w_reg_addr_nxt;
    logic [7:0]          w_reg_wdata_nxt;
    logic                w_reg_we_nxt;
    logic                w_reg_re_nxt;
    logic                w_frame_err_nxt;
    logic                w_launch;
    logic                w_in_get;
    logic                w_timeout;

    assign w_in_get = (r_state == S_GET_ADDR) || (r_state == S_GET_DATA);

`ifdef UART_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] r_idle_cnt;

    // Idle clocks since the last received byte of a partial command
    always_ff @(posedge clk) begin
        if (rst || rx_ready || !w_in_get) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    assign w_timeout = w_in_get && !rx_ready &&
                       (r_idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // No timeout in this build; TIMEOUT_CYCLES stays referenced so both
    // builds share an identical parameter list.
    assign w_timeout = 1'b0 && (TIMEOUT_CYCLES == 0);
`endif

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cmd_rd    <= 1'b0;
            r_tx_data   <= 8'h00;
            r_tx_start  <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_wdata <= 8'h00;
            r_reg_we    <= 1'b0;
            r_reg_re    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_rd    <= w_cmd_rd_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_tx_start  <= w_tx_start_nxt;
            r_reg_addr  <= w_reg_addr_nxt;
            r_reg_wdata <= w_reg_wdata_nxt;
            r_reg_we    <= w_reg_we_nxt;
            r_reg_re    <= w_reg_re_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    // Next-state and next-output decode; a ready response is launched in the
    // same transition when the transmitter is free, otherwise it waits in TX_SEND
    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_rd_nxt    = r_cmd_rd;
        w_tx_data_nxt   = r_tx_data;
        w_tx_start_nxt  = 1'b0;
        w_reg_addr_nxt  = r_reg_addr;
        w_reg_wdata_nxt = r_reg_wdata;
        w_reg_we_nxt    = 1'b0;
        w_reg_re_nxt    = 1'b0;
        w_launch        = 1'b0;
        // Bytes arriving while a command executes or its answer is pending are dropped
        w_frame_err_nxt = rx_ready && !(r_state == S_IDLE || w_in_get);

        case (r_state)
            S_IDLE: begin
                if (rx_ready) begin
                    if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                        w_cmd_rd_nxt = (rx_data == CMD_RD);
                        w_state_nxt  = S_GET_ADDR;
                    end else begin
                        w_tx_data_nxt   = RSP_ERR;
                        w_frame_err_nxt = 1'b1;
                        w_launch        = 1'b1;
                    end
                end
            end
            S_GET_ADDR: begin
                if (rx_ready) begin
                    w_reg_addr_nxt = ADDR_W'(rx_data);
                    if (r_cmd_rd) begin
                        w_reg_re_nxt = 1'b1;
                        w_state_nxt  = S_BUS_RD;
                    end else begin
                        w_state_nxt  = S_GET_DATA;
                    end
                end else if (w_timeout) begin
                    w_frame_err_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                end
            end
            S_GET_DATA: begin
                if (rx_ready) begin
                    w_reg_wdata_nxt = rx_data;
                    w_reg_we_nxt    = 1'b1;
                    w_state_nxt     = S_BUS_WR;
                end else if (w_timeout) begin
                    w_frame_err_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                end
            end
            S_BUS_WR: begin
                w_tx_data_nxt = RSP_OK;
                w_launch      = 1'b1;
            end
            S_BUS_RD: begin
                w_state_nxt = S_RD_CAP;
            end
            S_RD_CAP: begin
                w_tx_data_nxt = reg_rdata;
                w_launch      = 1'b1;
            end
            S_TX_SEND: begin
                if (!tx_busy) begin
                    w_tx_start_nxt = 1'b1;
                    w_state_nxt    = S_TX_WAIT;
                end
            end
            S_TX_WAIT: begin
                // The tx_start cycle itself is the first cycle here; busy may not be up yet
                if (!r_tx_start && !tx_busy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_launch) begin
            if (!tx_busy) begin
                w_tx_start_nxt = 1'b1;
                w_state_nxt    = S_TX_WAIT;
            end else begin
                w_state_nxt    = S_TX_SEND;
            end
        end
    end

    assign tx_data   = r_tx_data;
    assign tx_start  = r_tx_start;
    assign reg_addr  = r_reg_addr;
    assign reg_wdata = r_reg_wdata;
    assign reg_we    = r_reg_we;
    assign reg_re    = r_reg_re;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Testbench for uart_reg_bridge: random commands checked against a
// reference register map and the command/response timing rules.
module tb_uart_reg_bridge;

    localparam int T_OUT = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy = 1'b0;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'h00;
    logic       frame_err;

    uart_reg_bridge #(.ADDR_W(8), .TIMEOUT_CYCLES(T_OUT)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
        .reg_re(reg_re), .reg_rdata(reg_rdata), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [7:0] a; logic [7:0] d; } ev_t;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    ev_t  we_q[$];
    ev_t  re_q[$];
    ev_t  tx_q[$];
    int   fe_q[$];
    logic [7:0] mem   [256];
    logic [7:0] model [256];
    logic hold_busy = 1'b0;
    int   busy_cnt = 0;
    logic rd_hold = 1'b0;
    logic [7:0] cur_tx = 8'h00;
    int   busy_viol = 0;
    int   hold_viol = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event logger plus register-slave and transmitter models
    always @(negedge clk) begin
        if (reg_we) we_q.push_back('{cyc, reg_addr, reg_wdata});
        if (reg_re) re_q.push_back('{cyc, reg_addr, 8'h00});
        if (frame_err) fe_q.push_back(cyc);
        if (busy_cnt > 0 && tx_data !== cur_tx) hold_viol++;
        if (tx_start) begin
            tx_q.push_back('{cyc, 8'h00, tx_data});
            if (tx_busy) busy_viol++;
            cur_tx = tx_data;
            busy_cnt = 3 + int'($urandom_range(0, 4));
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        tx_busy = hold_busy || (busy_cnt > 0);
        if (reg_we) mem[reg_addr] = reg_wdata;
        if (reg_re) begin
            reg_rdata = mem[reg_addr];
            rd_hold = 1'b1;
        end else if (rd_hold) begin
            rd_hold = 1'b0;
        end else begin
            reg_rdata = 8'($urandom);
        end
    end

    function automatic ev_t head(input ev_t q[$]);
        ev_t e;
        if (q.size() > 0) e = q[0];
        else e = '{-1, 8'h00, 8'h00};
        return e;
    endfunction

    function automatic int head_i(input int q[$]);
        return (q.size() > 0) ? q[0] : -1;
    endfunction

    task automatic clear_logs();
        we_q.delete(); re_q.delete(); tx_q.delete(); fe_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, output int n);
        @(posedge clk); #1;
        rx_data = b; rx_ready = 1'b1; n = cyc;
        @(posedge clk); #1;
        rx_ready = 1'b0; rx_data = 8'($urandom);
    endtask

    task automatic settle();
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL rst_tx_data: got %02h expected 00", tx_data); end
        checks++; if (reg_addr !== 8'h00) begin failures++; $display("FAIL rst_reg_addr: got %02h expected 00", reg_addr); end
        checks++; if (reg_wdata !== 8'h00) begin failures++; $display("FAIL rst_reg_wdata: got %02h expected 00", reg_wdata); end
        checks++; if ({tx_start, reg_we, reg_re, frame_err} !== 4'b0000) begin
            failures++; $display("FAIL rst_strobes: got %b expected 0000", {tx_start, reg_we, reg_re, frame_err});
        end
        rst = 1'b0;
        settle();
    endtask

    task automatic test_write(input logic [7:0] a, input logic [7:0] d);
        int n, dummy;
        ev_t e;
        clear_logs();
        send_byte(8'h57, dummy);
        send_byte(a, dummy);
        send_byte(d, n);
        settle();
        e = head(we_q);
        checks++; if (we_q.size() != 1) begin failures++; $display("FAIL wr_count: got %0d expected 1", we_q.size()); end
        checks++; if (e.cyc != n + 1 || e.a !== a || e.d !== d) begin
            failures++; $display("FAIL wr_strobe: got cyc=%0d addr=%02h data=%02h expected cyc=%0d addr=%02h data=%02h", e.cyc, e.a, e.d, n + 1, a, d);
        end
        e = head(tx_q);
        checks++; if (tx_q.size() != 1 || e.cyc != n + 2 || e.d !== 8'h4B) begin
            failures++; $display("FAIL wr_resp: got n=%0d cyc=%0d data=%02h expected n=1 cyc=%0d data=4b", tx_q.size(), e.cyc, e.d, n + 2);
        end
        checks++; if (fe_q.size() != 0 || re_q.size() != 0) begin
            failures++; $display("FAIL wr_side: got frame_err=%0d reads=%0d expected 0 0", fe_q.size(), re_q.size());
        end
        checks++; if (reg_addr !== a || reg_wdata !== d) begin
            failures++; $display("FAIL wr_hold: got addr=%02h data=%02h expected %02h %02h", reg_addr, reg_wdata, a, d);
        end
        model[a] = d;
    endtask

    task automatic test_read(input logic [7:0] a);
        int n, dummy;
        ev_t e;
        clear_logs();
        send_byte(8'h52, dummy);
        send_byte(a, n);
        settle();
        e = head(re_q);
        checks++; if (re_q.size() != 1 || e.cyc != n + 1 || e.a !== a) begin
            failures++; $display("FAIL rd_strobe: got n=%0d cyc=%0d addr=%02h expected n=1 cyc=%0d addr=%02h", re_q.size(), e.cyc, e.a, n + 1, a);
        end
        e = head(tx_q);
        checks++; if (tx_q.size() != 1 || e.cyc != n + 3 || e.d !== model[a]) begin
            failures++; $display("FAIL rd_resp: got n=%0d cyc=%0d data=%02h expected n=1 cyc=%0d data=%02h", tx_q.size(), e.cyc, e.d, n + 3, model[a]);
        end
        checks++; if (fe_q.size() != 0 || we_q.size() != 0) begin
            failures++; $display("FAIL rd_side: got frame_err=%0d writes=%0d expected 0 0", fe_q.size(), we_q.size());
        end
    endtask

    task automatic test_unknown(input logic [7:0] b);
        int n;
        ev_t e;
        clear_logs();
        send_byte(b, n);
        settle();
        e = head(tx_q);
        checks++; if (tx_q.size() != 1 || e.cyc != n + 1 || e.d !== 8'h3F) begin
            failures++; $display("FAIL unk_resp: got n=%0d cyc=%0d data=%02h expected n=1 cyc=%0d data=3f", tx_q.size(), e.cyc, e.d, n + 1);
        end
        checks++; if (fe_q.size() != 1 || head_i(fe_q) != n + 1) begin
            failures++; $display("FAIL unk_frame_err: got n=%0d cyc=%0d expected n=1 cyc=%0d", fe_q.size(), head_i(fe_q), n + 1);
        end
        checks++; if (we_q.size() != 0 || re_q.size() != 0) begin
            failures++; $display("FAIL unk_bus: got writes=%0d reads=%0d expected 0 0", we_q.size(), re_q.size());
        end
    endtask

    task automatic test_busy_stall();
        int n, m, dummy;
        ev_t e;
        logic [7:0] a, d;
        a = 8'($urandom); d = 8'($urandom);
        @(posedge clk); #1;
        hold_busy = 1'b1;
        repeat (3) @(posedge clk);
        clear_logs();
        send_byte(8'h57, dummy);
        send_byte(a, dummy);
        send_byte(d, n);
        repeat (100) @(posedge clk);
        checks++; if (tx_q.size() != 0) begin failures++; $display("FAIL busy_early_start: got %0d starts expected 0", tx_q.size()); end
        #1;
        hold_busy = 1'b0;
        m = cyc;
        settle();
        e = head(tx_q);
        checks++; if (tx_q.size() != 1 || e.cyc != m + 1 || e.d !== 8'h4B) begin
            failures++; $display("FAIL busy_resp: got n=%0d cyc=%0d data=%02h expected n=1 cyc=%0d data=4b", tx_q.size(), e.cyc, e.d, m + 1);
        end
        e = head(we_q);
        checks++; if (we_q.size() != 1 || e.cyc != n + 1) begin
            failures++; $display("FAIL busy_wr: got n=%0d cyc=%0d expected n=1 cyc=%0d", we_q.size(), e.cyc, n + 1);
        end
        model[a] = d;
    endtask

    task automatic test_dropped_byte();
        int n, s, dummy;
        ev_t e;
        logic [7:0] a;
        a = 8'($urandom);
        clear_logs();
        send_byte(8'h52, dummy);
        send_byte(a, n);
        repeat (2) @(posedge clk);
        send_byte(8'h57, s);
        settle();
        checks++; if (fe_q.size() != 1 || head_i(fe_q) != s + 1) begin
            failures++; $display("FAIL drop_frame_err: got n=%0d cyc=%0d expected n=1 cyc=%0d", fe_q.size(), head_i(fe_q), s + 1);
        end
        e = head(tx_q);
        checks++; if (tx_q.size() != 1 || e.cyc != n + 3 || e.d !== model[a]) begin
            failures++; $display("FAIL drop_resp: got n=%0d cyc=%0d data=%02h expected n=1 cyc=%0d data=%02h", tx_q.size(), e.cyc, e.d, n + 3, model[a]);
        end
        checks++; if (re_q.size() != 1 || we_q.size() != 0) begin
            failures++; $display("FAIL drop_bus: got reads=%0d writes=%0d expected 1 0", re_q.size(), we_q.size());
        end
        test_write(8'($urandom), 8'($urandom));
    endtask

    task automatic test_reset_mid();
        int dummy, n;
        ev_t e;
        clear_logs();
        send_byte(8'h57, dummy);
        send_byte(8'h80 | 8'($urandom), dummy);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if ({tx_start, reg_we, reg_re, frame_err} !== 4'b0000 || reg_addr !== 8'h00) begin
            failures++; $display("FAIL rstmid_outputs: got strobes=%b addr=%02h expected 0000 00", {tx_start, reg_we, reg_re, frame_err}, reg_addr);
        end
        repeat (3) @(posedge clk);
        checks++; if (we_q.size() != 0 || re_q.size() != 0 || tx_q.size() != 0) begin
            failures++; $display("FAIL rstmid_quiet: got we=%0d re=%0d tx=%0d expected 0 0 0", we_q.size(), re_q.size(), tx_q.size());
        end
        clear_logs();
        send_byte(8'h99, n);
        settle();
        e = head(tx_q);
        checks++; if (tx_q.size() != 1 || e.cyc != n + 1 || e.d !== 8'h3F || we_q.size() != 0) begin
            failures++; $display("FAIL rstmid_resp: got n=%0d cyc=%0d data=%02h we=%0d expected n=1 cyc=%0d data=3f we=0", tx_q.size(), e.cyc, e.d, we_q.size(), n + 1);
        end
    endtask

`ifdef UART_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        clear_logs();
        send_byte(8'h57, n);
        repeat (25) @(posedge clk);
        checks++; if (fe_q.size() != 1 || head_i(fe_q) < n + T_OUT || head_i(fe_q) > n + T_OUT + 1) begin
            failures++; $display("FAIL timeout_frame_err: got n=%0d cyc=%0d expected n=1 cyc=%0d..%0d", fe_q.size(), head_i(fe_q), n + T_OUT, n + T_OUT + 1);
        end
        checks++; if (we_q.size() != 0 || tx_q.size() != 0) begin
            failures++; $display("FAIL timeout_side: got we=%0d tx=%0d expected 0 0", we_q.size(), tx_q.size());
        end
        test_read(8'h01);
    endtask
`endif

    task automatic test_back_to_back();
        logic [7:0] b;
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 2))
                0: test_write(8'($urandom), 8'($urandom));
                1: test_read(8'($urandom_range(0, 15)));
                default: begin
                    b = 8'($urandom);
                    while (b == 8'h57 || b == 8'h52) b = 8'($urandom);
                    test_unknown(b);
                end
            endcase
        end
    endtask

    task automatic test_invariants();
        checks++; if (busy_viol != 0) begin failures++; $display("FAIL start_while_busy: got %0d expected 0", busy_viol); end
        checks++; if (hold_viol != 0) begin failures++; $display("FAIL tx_data_hold: got %0d changes expected 0", hold_viol); end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        rst = 1'b1; rx_ready = 1'b0; rx_data = 8'h00;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            mem[i] = v;
            model[i] = v;
        end
        test_reset();
        test_write(8'h05, 8'hA5);
        test_read(8'h05);
        test_write(8'h05, 8'h3C);
        test_read(8'h05);
        test_read(8'($urandom));
        test_unknown(8'h41);
        test_busy_stall();
        test_dropped_byte();
        test_reset_mid();
`ifdef UART_BRIDGE_TIMEOUT_EN
        test_timeout();
`endif
        for (int i = 0; i < 16; i++) test_write(8'(i), 8'($urandom));
        test_back_to_back();
        test_invariants();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_reg_bridge.md
# uart_reg_bridge

Byte-level command responder sitting on the host side of the UART byte interface (`rx_data`/`rx_ready` in, `tx_data`/`tx_start`/`tx_busy` out). It decodes a 2- or 3-byte read/write command stream from the remote PC and drives a simple single-cycle register bus. It returns exactly one response byte per accepted command. All on-chip control and status registers are reachable over the serial link without a CPU.

## Interface
- `ADDR_W`, 8: register bus address width; address byte truncated to `ADDR_W` bits.
- `TIMEOUT_CYCLES`, 50000000: idle clocks allowed between bytes of one command (1 s at 50 MHz).
- `clk`  in  1: system clock, 50 MHz.
- `rst`  in  1: synchronous, active-high reset.
- `rx_data`  in  8: received byte; valid when `rx_ready`=1.
- `rx_ready`  in  1: one-cycle pulse per received byte.
- `tx_data`  out  8: byte to transmit; held stable from `tx_start` until `tx_busy` falls.
- `tx_start`  out  1: one-cycle transmit request.
- `tx_busy`  in  1: transmitter busy.
- `reg_addr`  out  `ADDR_W`: bus address.
- `reg_wdata`  out  8: bus write data.
- `reg_we`  out  1: one-cycle write strobe.
- `reg_re`  out  1: one-cycle read strobe.
- `reg_rdata`  in  8: read data, valid the cycle after `reg_re`.
- `frame_err`  out  1: one-cycle pulse on unknown command, timeout or dropped byte.

## Operation
- Commands: 0x57 'W', addr, data -> write, respond 0x4B 'K'. 0x52 'R', addr -> read, respond the read byte. Any other first byte -> respond 0x3F '?' and pulse `frame_err`.
- States: IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, RD_CAP, TX_SEND, TX_WAIT.
- IDLE + `rx_ready`:
  - 'W' or 'R' -> GET_ADDR, command latched.
  - Other value -> TX_SEND with 0x3F.
- GET_ADDR + `rx_ready`: latch address. Then 'R' -> BUS_RD; 'W' -> GET_DATA.
- GET_DATA + `rx_ready`: latch data -> BUS_WR.
- BUS_WR: `reg_we`=1 for one cycle -> TX_SEND with 0x4B.
- BUS_RD: `reg_re`=1 for one cycle -> RD_CAP.
- RD_CAP: capture `reg_rdata` into `tx_data` -> TX_SEND.
- TX_SEND: wait for `tx_busy`=0, then pulse `tx_start` -> TX_WAIT.
  - TX_WAIT ignores `tx_busy` in its first cycle, then returns to IDLE when `tx_busy`=0.
- `rx_ready` in BUS_*, RD_CAP or TX_* states: byte discarded, `frame_err` pulses, state unaffected.
- All outputs registered. Reset values: `tx_data`=0x00, `reg_addr`=0, `reg_wdata`=0x00; `tx_start`, `reg_we`, `reg_re`, `frame_err`=0; state IDLE.
- Reset mid-command or mid-transmit: abandon immediately. No bus strobe and no `tx_start` in the cycle after `rst` deasserts.

## Timing
- Final byte's `rx_ready` in cycle N:
  - Write: `reg_we` in N+1; `tx_start` in N+2 if `tx_busy`=0.
  - Read: `reg_re` in N+1; `reg_rdata` sampled at end of N+2; `tx_start` in N+3.
  - Unknown command: `tx_start` in N+1, `frame_err` in N+1.
- `reg_addr`/`reg_wdata` stable during the strobe cycle and held afterwards until next command.
- Never more than one `tx_start` per command. `tx_start` is never asserted while `tx_busy`=1.

## Configuration
- `UART_BRIDGE_TIMEOUT_EN` defined: in GET_ADDR/GET_DATA, a counter of cycles since the last `rx_ready` runs.
  - Reaching `TIMEOUT_CYCLES` -> return to IDLE, pulse `frame_err`, no response byte.
  - Counter clears on every `rx_ready` and in IDLE.
- Not defined: no counter logic; partial commands wait indefinitely.

## Test plan
- After reset, 0x57,0x05,0xA5 -> `reg_we` one cycle with addr 0x05, data 0xA5; `tx_start` with `tx_data`=0x4B; `frame_err` never.
- 0x52,0x05 with `reg_rdata`=0x3C the cycle after `reg_re` -> `reg_re` one cycle at addr 0x05, then `tx_data`=0x3C with `tx_start` at N+3.
- 0x41 -> `tx_data`=0x3F, `frame_err` one pulse, no bus strobe.
- `tx_busy` held high 100 cycles while a write response is pending -> `tx_start` first asserted the cycle `tx_busy` is seen low; single pulse.
- With `UART_BRIDGE_TIMEOUT_EN` and `TIMEOUT_CYCLES`=20: 0x57 then silence 25 cycles, then 0x52,0x01 -> `frame_err` at cycle 20, no `reg_we`, then normal read.
- `rst` pulse between address and data bytes of a write, then 0x99 -> no `reg_we`; response 0x3F.
